// File: rtl/switch_playback.sv
// Replays (level, duration) entries from the recorder's ring buffer onto play_switch.
// play_switch, busy and done are registered; rd_en/rd_addr are decoded from the state.
module switch_playback #(
  parameter int DEPTH    = 20,
  parameter int IDX_W    = 5,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 100
) (
  input  logic             Div_CLK,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_en,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [IDX_W:0]   num_entries,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  input  logic             rd_level,
  input  logic [DUR_W-1:0] rd_dur,
  output logic             play_switch,
  output logic             busy,
  output logic             done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, base_q, base_d;
  logic [IDX_W:0]   num_q, num_d, cnt_q, cnt_d, cnt_inc;
  logic [DUR_W-1:0] tick_q, tick_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             lvl_q, lvl_d, play_q, play_d, busy_q, busy_d, done_q, done_d;
  logic             accept, killed, skip, tick_end, entry_end, list_end;

  assign accept    = (state_q == S_IDLE) && start && !abort;
  assign killed    = abort && (state_q != S_IDLE);
  assign cnt_inc   = cnt_q + 1'b1;
  assign list_end  = (cnt_inc == num_q);
  assign skip      = (state_q == S_WAIT) && (rd_dur == '0);
  assign tick_end  = (state_q == S_PLAY) && (pre_q == PRE_LAST) && (tick_q == DUR_W'(1));
  assign entry_end = skip || tick_end;

  // State register
  always_ff @(posedge Div_CLK or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (killed) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = (num_entries != '0) ? S_FETCH : S_DONE;
        S_FETCH: state_d = S_WAIT;
        S_WAIT:  if (skip) state_d = (list_end && !loop_en) ? S_DONE : S_FETCH;
                 else      state_d = S_PLAY;
        S_PLAY:  if (tick_end) state_d = (list_end && !loop_en) ? S_DONE : S_FETCH;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decoded outputs
  always_comb begin
    rd_en   = (state_q == S_FETCH);
    rd_addr = idx_q;
  end

  always_comb begin
    idx_d  = idx_q;
    base_d = base_q;
    num_d  = num_q;
    cnt_d  = cnt_q;
    tick_d = tick_q;
    pre_d  = pre_q;
    lvl_d  = lvl_q;
    if (accept && (num_entries != '0)) begin
      idx_d  = start_idx;
      base_d = start_idx;
      num_d  = num_entries;
      cnt_d  = '0;
    end
    if ((state_q == S_WAIT) && !skip) begin
      lvl_d  = rd_level;
      tick_d = rd_dur;
      pre_d  = '0;
    end
    if (state_q == S_PLAY) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = tick_q - 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    // End of list always rewinds; a non-looping pass simply never fetches again
    if (entry_end) begin
      if (list_end) begin
        idx_d = base_q;
        cnt_d = '0;
      end else begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        cnt_d = cnt_inc;
      end
    end
    play_d = lvl_q;
    if (killed || (state_q == S_DONE)) begin
      lvl_d  = 1'b0;
      play_d = 1'b0;
    end
    busy_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_PLAY);
    done_d = (state_q == S_DONE) && !abort;
  end

  always_ff @(posedge Div_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      idx_q  <= '0;
      base_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      tick_q <= '0;
      pre_q  <= '0;
      lvl_q  <= 1'b0;
      play_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
      num_q  <= num_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      pre_q  <= pre_d;
      lvl_q  <= lvl_d;
      play_q <= play_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign play_switch = play_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_switch_playback.sv
// Bench for switch_playback: fixed scenario table, hand-written abort/reset/loop sequences,
// and random playbacks compared against a timeline model of the replay rules.
module tb_switch_playback;
  localparam int DEPTH = 20;
  localparam int IDX_W = 5;
  localparam int DUR_W = 8;
  localparam int TD    = 4;
  localparam int MAXW  = 160;

  logic             clk;
  logic             rst_n;
  logic             start, abort, loop_en;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W:0]   num;
  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;
  logic             rd_level;
  logic [DUR_W-1:0] rd_dur;
  logic             play, busy, done;

  logic             mem_lvl [DEPTH];
  logic [DUR_W-1:0] mem_dur [DEPTH];

  int checks = 0;
  int fails  = 0;

  int s_play [MAXW];
  int s_busy [MAXW];
  int s_done [MAXW];
  int s_rd   [MAXW];

  switch_playback #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DUR_W(DUR_W), .TICK_DIV(TD)) dut (
    .Div_CLK(clk), .Rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
    .start_idx(start_idx), .num_entries(num), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_level(rd_level), .rd_dur(rd_dur), .play_switch(play), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous record memory: data valid the cycle after rd_en
  initial begin
    rd_level = 1'b0;
    rd_dur   = '0;
  end
  always @(posedge clk) begin
    if (rd_en) begin
      rd_level <= mem_lvl[rd_addr];
      rd_dur   <= mem_dur[rd_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; pulses start over one edge and samples W cycles after the accept edge.
  task automatic run_capture(input int idx, input int n, input int w);
    start_idx = IDX_W'(idx);
    num       = (IDX_W+1)'(n);
    start     = 1'b1;
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      s_play[k] = int'(play);
      s_busy[k] = int'(busy);
      s_done[k] = int'(done);
      s_rd[k]   = rd_en ? int'(rd_addr) : -1;
    end
  endtask

  task automatic load_fixed_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem_lvl[i] = 1'b0;
      mem_dur[i] = 8'd1;
    end
    mem_lvl[0] = 1'b1; mem_dur[0] = 8'd3;
    mem_lvl[1] = 1'b0; mem_dur[1] = 8'd2;
    mem_lvl[2] = 1'b1; mem_dur[2] = 8'd0;
    mem_lvl[3] = 1'b1; mem_dur[3] = 8'd1;
    mem_lvl[4] = 1'b1; mem_dur[4] = 8'd2;
    mem_lvl[5] = 1'b1; mem_dur[5] = 8'd0;
    mem_lvl[6] = 1'b0; mem_dur[6] = 8'd1;
    mem_lvl[19] = 1'b1; mem_dur[19] = 8'd2;
  endtask

  typedef struct {
    int sidx;
    int num;
    int exp_busy;
    int exp_high;
    int exp_reads;
    int exp_addr_sum;
    int exp_done_at;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int nb, nh, nr, asum, nd, dat, first_hi;
    int e_play [MAXW];
    int e_busy [MAXW];
    int e_done [MAXW];
    int e_rd   [MAXW];
    int ev_edge [$];
    int ev_lvl  [$];
    int c, w, sidx, n, a, d, lv;
    int addrs [$];

    vecs[0] = '{0,  2, 24, 14, 2, 1,  25};
    vecs[1] = '{19, 3, 34, 24, 3, 20, 35};
    vecs[2] = '{1,  3, 18, 4,  3, 6,  19};
    vecs[3] = '{2,  2, 8,  4,  2, 5,  9};
    vecs[4] = '{0,  4, 32, 18, 4, 6,  33};
    vecs[5] = '{4,  3, 18, 12, 3, 15, 19};
    vecs[6] = '{7,  0, 0,  0,  0, 0,  1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    start_idx = '0; num = '0;
    load_fixed_mem();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_play", play, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Scenario table
    for (int v = 0; v < 7; v++) begin
      run_capture(vecs[v].sidx, vecs[v].num, vecs[v].exp_done_at + 4);
      nb = 0; nh = 0; nr = 0; asum = 0; nd = 0; dat = -1; first_hi = -1;
      for (int k = 0; k < vecs[v].exp_done_at + 4; k++) begin
        nb += s_busy[k];
        nh += s_play[k];
        if (s_play[k] == 1 && first_hi < 0) first_hi = k;
        if (s_rd[k] >= 0) begin nr++; asum += s_rd[k]; end
        if (s_done[k] == 1) begin nd++; dat = k; end
      end
      chk($sformatf("vec%0d_busy_cycles", v), nb, vecs[v].exp_busy);
      chk($sformatf("vec%0d_high_cycles", v), nh, vecs[v].exp_high);
      chk($sformatf("vec%0d_reads", v), nr, vecs[v].exp_reads);
      chk($sformatf("vec%0d_addr_sum", v), asum, vecs[v].exp_addr_sum);
      chk($sformatf("vec%0d_done_count", v), nd, 1);
      chk($sformatf("vec%0d_done_at", v), dat, vecs[v].exp_done_at);
      if (v == 0) chk("vec0_first_change", first_hi, 3);
    end

    // Abort mid-PLAY
    start_idx = '0; num = 7'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_play", play, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_play", play, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    nd = 0; nr = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      nd += int'(done);
      nr += int'(rd_en);
    end
    chk("abort_no_done", nd, 0);
    chk("abort_no_reads", nr, 0);

    // Start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    nr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      nr += int'(rd_en) + int'(done) + int'(busy);
    end
    chk("start_abort_idle", nr, 0);

    // Reset mid-PLAY
    start_idx = '0; num = 7'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_play", play, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      nd += int'(done) + int'(rd_en);
    end
    chk("rst_mid_quiet", nd, 0);

    // Looping playback, loop_en cleared during pass 2, start pulses while busy ignored
    loop_en = 1'b1;
    start_idx = '0; num = 7'd2; start = 1'b1;
    addrs.delete();
    nd = 0; dat = -1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 5) begin start = 1'b1; start_idx = 5'd3; num = 7'd1; end
      if (k == 6) start = 1'b0;
      if (rd_en) addrs.push_back(int'(rd_addr));
      if (addrs.size() == 3) loop_en = 1'b0;
      if (k == 30) chk("loop_busy_pass2", busy, 1);
      if (done) begin nd++; dat = k; end
      if (dat >= 0 && k > dat + 3) break;
    end
    chk("loop_reads", addrs.size(), 4);
    if (addrs.size() == 4) begin
      chk("loop_addr0", addrs[0], 0);
      chk("loop_addr1", addrs[1], 1);
      chk("loop_addr2", addrs[2], 0);
      chk("loop_addr3", addrs[3], 1);
    end
    chk("loop_done_count", nd, 1);
    chk("loop_done_at", dat, 49);
    loop_en = 1'b0;
    repeat (2) @(negedge clk);

    // Random playbacks against the timeline model
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_lvl[i] = 1'($urandom % 2);
        mem_dur[i] = DUR_W'($urandom % 4);
      end
      sidx = int'($urandom % DEPTH);
      n    = int'($urandom_range(0, 7));
      ev_edge.delete(); ev_lvl.delete();
      for (int k = 0; k < MAXW; k++) e_rd[k] = -1;
      c = 0;
      for (int j = 0; j < n; j++) begin
        a = (sidx + j) % DEPTH;
        e_rd[c] = a;
        d = int'(mem_dur[a]);
        if (d != 0) begin
          ev_edge.push_back(c + 3);
          ev_lvl.push_back(int'(mem_lvl[a]));
        end
        c += 2 + d * TD;
      end
      w = c + 4;
      for (int k = 0; k < w; k++) begin
        lv = 0;
        for (int i = 0; i < ev_edge.size(); i++)
          if (ev_edge[i] <= k) lv = ev_lvl[i];
        if (k >= c + 1) lv = 0;
        e_play[k] = lv;
        e_busy[k] = (k < c) ? 1 : 0;
        e_done[k] = (k == c + 1) ? 1 : 0;
      end
      run_capture(sidx, n, w);
      for (int k = 0; k < w; k++) begin
        chk($sformatf("rand_play t%0d k%0d", t, k), s_play[k], e_play[k]);
        chk($sformatf("rand_busy t%0d k%0d", t, k), s_busy[k], e_busy[k]);
        chk($sformatf("rand_done t%0d k%0d", t, k), s_done[k], e_done[k]);
        chk($sformatf("rand_rd t%0d k%0d", t, k), s_rd[k], e_rd[k]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
